// File: rtl/jtkcpu_regs.sv
// KONAMI-2 programmer-visible register file: A, B (D=A:B), X, Y, U, S, DP, CC.
// Ports: rst/clk/cen; rd_sel->opnd0 read mux; wr0/wr1 ALU writeback; cc_we/cc_alu;
// xfr_* TFR/EXG; ptr_* pointer step; a,b,x,y,u,s,dp,cc contents; nmi_arm.
// Optional macro JTKCPU_REGS_SHADOW_EN adds shd_save/shd_rest shadow bank.
module jtkcpu_regs #(
  parameter logic [7:0] CC_RST = 8'h50
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [3:0]  rd_sel,
  output logic [15:0] opnd0,
  input  logic        wr0_en,
  input  logic [3:0]  wr0_sel,
  input  logic [15:0] wr0_data,
  input  logic        wr1_en,
  input  logic [3:0]  wr1_sel,
  input  logic [15:0] wr1_data,
  input  logic        cc_we,
  input  logic [7:0]  cc_alu,
  input  logic        xfr_en,
  input  logic        xfr_exg,
  input  logic [7:0]  xfr_pb,
  input  logic        ptr_en,
  input  logic [1:0]  ptr_sel,
  input  logic        ptr_dec,
  input  logic        ptr_two,
`ifdef JTKCPU_REGS_SHADOW_EN
  input  logic        shd_save,
  input  logic        shd_rest,
`endif
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [7:0]  dp,
  output logic [7:0]  cc,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [15:0] u,
  output logic [15:0] s,
  output logic        nmi_arm
);

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] u;
    logic [15:0] s;
    logic [7:0]  dp;
    logic [7:0]  cc;
  } regs_t;

  regs_t       q, nx;
  logic        s_hit;
  logic [3:0]  src, dst;
  logic [15:0] step;

  function automatic logic [15:0] rd(regs_t r, logic [3:0] c);
    case (c)
      4'd0:    rd = {8'h00, r.a};
      4'd1:    rd = {8'h00, r.b};
      4'd2:    rd = {r.a, r.b};
      4'd3:    rd = r.x;
      4'd4:    rd = r.y;
      4'd5:    rd = r.u;
      4'd6:    rd = r.s;
      4'd7:    rd = {8'h00, r.cc};
      4'd8:    rd = {8'h00, r.dp};
      default: rd = 16'h0000;
    endcase
  endfunction

  // Invalid codes behave as 16-bit zero sources
  function automatic logic is16(logic [3:0] c);
    is16 = !(c == 4'd0 || c == 4'd1 || c == 4'd7 || c == 4'd8);
  endfunction

  function automatic regs_t put(regs_t r, logic [3:0] c, logic [15:0] d);
    put = r;
    case (c)
      4'd0:    put.a = d[7:0];
      4'd1:    put.b = d[7:0];
      4'd2:    {put.a, put.b} = d;
      4'd3:    put.x = d;
      4'd4:    put.y = d;
      4'd5:    put.u = d;
      4'd6:    put.s = d;
      4'd7:    put.cc = d[7:0];
      4'd8:    put.dp = d[7:0];
      default: put = r;
    endcase
  endfunction

  function automatic logic [15:0] conv(logic [15:0] v, logic s16, logic d16);
    if (!s16 && d16)      conv = {8'hFF, v[7:0]};
    else if (s16 && !d16) conv = {8'h00, v[7:0]};
    else                  conv = v;
  endfunction

  function automatic logic [15:0] adj(logic [15:0] v, logic dec, logic [15:0] st);
    adj = dec ? v - st : v + st;
  endfunction

  assign src   = xfr_pb[7:4];
  assign dst   = xfr_pb[3:0];
  assign step  = ptr_two ? 16'd2 : 16'd1;
  assign opnd0 = rd(q, rd_sel);

`ifdef JTKCPU_REGS_SHADOW_EN
  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  dp;
    logic [7:0]  cc;
  } shd_t;

  shd_t sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh    <= '0;
      sh.cc <= CC_RST;
    end else if (cen && shd_save) begin
      sh <= '{a: q.a, b: q.b, x: q.x, y: q.y, dp: q.dp, cc: q.cc};
    end
  end
`endif

  // Sources applied lowest priority first so higher ones overwrite
  // only the registers/bytes they actually touch.
  always_comb begin
    nx    = q;
    s_hit = 1'b0;
    if (cc_we) nx.cc = cc_alu;
    if (ptr_en) begin
      case (ptr_sel)
        2'd0: nx.x = adj(q.x, ptr_dec, step);
        2'd1: nx.y = adj(q.y, ptr_dec, step);
        2'd2: nx.u = adj(q.u, ptr_dec, step);
        default: begin
          nx.s  = adj(q.s, ptr_dec, step);
          s_hit = 1'b1;
        end
      endcase
    end
    if (wr1_en) begin
      nx    = put(nx, wr1_sel, wr1_data);
      s_hit = s_hit | (wr1_sel == 4'd6);
    end
    if (wr0_en) begin
      nx    = put(nx, wr0_sel, wr0_data);
      s_hit = s_hit | (wr0_sel == 4'd6);
    end
    if (xfr_en) begin
      if (!xfr_exg) begin
        nx    = put(nx, dst, conv(rd(q, src), is16(src), is16(dst)));
        s_hit = s_hit | (dst == 4'd6);
      end else if (src != dst) begin
        nx    = put(nx, dst, conv(rd(q, src), is16(src), is16(dst)));
        nx    = put(nx, src, conv(rd(q, dst), is16(dst), is16(src)));
        s_hit = s_hit | (dst == 4'd6) | (src == 4'd6);
      end
    end
`ifdef JTKCPU_REGS_SHADOW_EN
    if (shd_rest) begin
      nx.a  = sh.a;
      nx.b  = sh.b;
      nx.x  = sh.x;
      nx.y  = sh.y;
      nx.dp = sh.dp;
      nx.cc = sh.cc;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q.cc    <= CC_RST;
      nmi_arm <= 1'b0;
    end else if (cen) begin
      q <= nx;
      if (s_hit) nmi_arm <= 1'b1;
    end
  end

  assign a  = q.a;
  assign b  = q.b;
  assign x  = q.x;
  assign y  = q.y;
  assign u  = q.u;
  assign s  = q.s;
  assign dp = q.dp;
  assign cc = q.cc;

endmodule

// File: tb/tb_jtkcpu_regs.sv
// Bench for jtkcpu_regs: directed steps then random cycles
// against a byte-cell register model.
module tb_jtkcpu_regs;

  logic        rst, clk, cen;
  logic [3:0]  rd_sel;
  logic [15:0] opnd0;
  logic        wr0_en, wr1_en, cc_we, xfr_en, xfr_exg;
  logic        ptr_en, ptr_dec, ptr_two;
  logic [3:0]  wr0_sel, wr1_sel;
  logic [15:0] wr0_data, wr1_data;
  logic [7:0]  cc_alu, xfr_pb;
  logic [1:0]  ptr_sel;
  logic [7:0]  a, b, dp, cc;
  logic [15:0] x, y, u, s;
  logic        nmi_arm;
`ifdef JTKCPU_REGS_SHADOW_EN
  logic        shd_save, shd_rest;
`endif

  jtkcpu_regs dut (
    .rst(rst), .clk(clk), .cen(cen),
    .rd_sel(rd_sel), .opnd0(opnd0),
    .wr0_en(wr0_en), .wr0_sel(wr0_sel), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_sel(wr1_sel), .wr1_data(wr1_data),
    .cc_we(cc_we), .cc_alu(cc_alu),
    .xfr_en(xfr_en), .xfr_exg(xfr_exg), .xfr_pb(xfr_pb),
    .ptr_en(ptr_en), .ptr_sel(ptr_sel),
    .ptr_dec(ptr_dec), .ptr_two(ptr_two),
`ifdef JTKCPU_REGS_SHADOW_EN
    .shd_save(shd_save), .shd_rest(shd_rest),
`endif
    .a(a), .b(b), .dp(dp), .cc(cc),
    .x(x), .y(y), .u(u), .s(s),
    .nmi_arm(nmi_arm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Cells: 0 A,1 B,2 XH,3 XL,4 YH,5 YL,6 UH,7 UL,8 SH,9 SL,10 CC,11 DP
  logic [7:0] mc [12];
  logic [7:0] nc [12];
  bit         claim [12];
  bit         m_arm;

  task automatic m_reset();
    for (int i = 0; i < 12; i++) mc[i] = 8'h00;
    mc[10] = 8'h50;
    m_arm  = 1'b0;
  endtask

  function automatic logic [15:0] mget(input logic [3:0] c);
    case (c)
      4'd0: return {8'h00, mc[0]};
      4'd1: return {8'h00, mc[1]};
      4'd2: return {mc[0], mc[1]};
      4'd3: return {mc[2], mc[3]};
      4'd4: return {mc[4], mc[5]};
      4'd5: return {mc[6], mc[7]};
      4'd6: return {mc[8], mc[9]};
      4'd7: return {8'h00, mc[10]};
      4'd8: return {8'h00, mc[11]};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic bit wide(input logic [3:0] c);
    return !(c == 4'd0 || c == 4'd1 || c == 4'd7 || c == 4'd8);
  endfunction

  function automatic logic [15:0] mconv(input logic [3:0] sc,
                                        input logic [3:0] dc,
                                        input logic [15:0] v);
    if (!wide(dc)) return {8'h00, v[7:0]};
    if (!wide(sc)) return {8'hFF, v[7:0]};
    return v;
  endfunction

  task automatic wcell(input int i, input logic [7:0] v);
    if (!claim[i]) begin
      nc[i]    = v;
      claim[i] = 1'b1;
    end
  endtask

  task automatic mput(input logic [3:0] c, input logic [15:0] d);
    case (c)
      4'd0: wcell(0, d[7:0]);
      4'd1: wcell(1, d[7:0]);
      4'd2: begin wcell(0, d[15:8]); wcell(1, d[7:0]); end
      4'd3: begin wcell(2, d[15:8]); wcell(3, d[7:0]); end
      4'd4: begin wcell(4, d[15:8]); wcell(5, d[7:0]); end
      4'd5: begin wcell(6, d[15:8]); wcell(7, d[7:0]); end
      4'd6: begin wcell(8, d[15:8]); wcell(9, d[7:0]); end
      4'd7: wcell(10, d[7:0]);
      4'd8: wcell(11, d[7:0]);
      default: ;
    endcase
  endtask

  // Highest priority claims its bytes first; later sources fill the rest
  task automatic m_step();
    logic [3:0]  sc, dc, pc;
    logic [15:0] pv;
    for (int i = 0; i < 12; i++) begin
      nc[i]    = mc[i];
      claim[i] = 1'b0;
    end
    sc = xfr_pb[7:4];
    dc = xfr_pb[3:0];
    if (xfr_en) begin
      if (!xfr_exg) begin
        mput(dc, mconv(sc, dc, mget(sc)));
        if (dc == 4'd6) m_arm = 1'b1;
      end else if (sc != dc) begin
        mput(dc, mconv(sc, dc, mget(sc)));
        mput(sc, mconv(dc, sc, mget(dc)));
        if (dc == 4'd6 || sc == 4'd6) m_arm = 1'b1;
      end
    end
    if (wr0_en) begin
      mput(wr0_sel, wr0_data);
      if (wr0_sel == 4'd6) m_arm = 1'b1;
    end
    if (wr1_en) begin
      mput(wr1_sel, wr1_data);
      if (wr1_sel == 4'd6) m_arm = 1'b1;
    end
    if (ptr_en) begin
      pc = 4'(ptr_sel) + 4'd3;
      pv = mget(pc);
      pv = ptr_dec ? pv - (ptr_two ? 16'd2 : 16'd1)
                   : pv + (ptr_two ? 16'd2 : 16'd1);
      mput(pc, pv);
      if (ptr_sel == 2'd3) m_arm = 1'b1;
    end
    if (cc_we) mput(4'd7, {8'h00, cc_alu});
    for (int i = 0; i < 12; i++) mc[i] = nc[i];
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a",   {8'h00, a},  {8'h00, mc[0]});
    chk("b",   {8'h00, b},  {8'h00, mc[1]});
    chk("x",   x,           {mc[2], mc[3]});
    chk("y",   y,           {mc[4], mc[5]});
    chk("u",   u,           {mc[6], mc[7]});
    chk("s",   s,           {mc[8], mc[9]});
    chk("cc",  {8'h00, cc}, {8'h00, mc[10]});
    chk("dp",  {8'h00, dp}, {8'h00, mc[11]});
    chk("nmi", {15'd0, nmi_arm}, {15'd0, m_arm});
    chk("opnd0", opnd0, mget(rd_sel));
  endtask

  task automatic idle();
    cen = 1'b1; rd_sel = 4'd0;
    wr0_en = 0; wr0_sel = 0; wr0_data = 0;
    wr1_en = 0; wr1_sel = 0; wr1_data = 0;
    cc_we = 0; cc_alu = 0;
    xfr_en = 0; xfr_exg = 0; xfr_pb = 0;
    ptr_en = 0; ptr_sel = 0; ptr_dec = 0; ptr_two = 0;
`ifdef JTKCPU_REGS_SHADOW_EN
    shd_save = 0; shd_rest = 0;
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    if (cen) m_step();
    #1;
    check_all();
    idle();
  endtask

  task automatic w0(input logic [3:0] c, input logic [15:0] d);
    wr0_en = 1; wr0_sel = c; wr0_data = d;
    cyc();
  endtask

  task automatic ptr(input logic [1:0] p, input bit dec, input bit two);
    ptr_en = 1; ptr_sel = p; ptr_dec = dec; ptr_two = two;
    cyc();
  endtask

  task automatic xfr(input bit exg, input logic [7:0] pb);
    xfr_en = 1; xfr_exg = exg; xfr_pb = pb;
    cyc();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    m_reset();
    #12;
    check_all();
    rd_sel = 4'd7; #1;
    chk("rst_cc_rd", opnd0, 16'h0050);
    chk("rst_nmi", {15'd0, nmi_arm}, 16'h0000);
    rst = 1'b0;

    w0(4'd2, 16'h1234);
    rd_sel = 4'd0; #1; chk("rd_a", opnd0, 16'h0012);
    rd_sel = 4'd1; #1; chk("rd_b", opnd0, 16'h0034);
    rd_sel = 4'd2; #1; chk("rd_d", opnd0, 16'h1234);

    wr0_en = 1; wr0_sel = 4'd4; wr0_data = 16'hBEEF;
    wr1_en = 1; wr1_sel = 4'd3; wr1_data = 16'h00FE;
    cyc();
    chk("lmul_x", x, 16'h00FE);
    chk("lmul_y", y, 16'hBEEF);

    cc_we = 1; cc_alu = 8'h01;
    wr0_en = 1; wr0_sel = 4'd7; wr0_data = 16'h00FF;
    cyc();
    chk("cc_ovr", {8'h00, cc}, 16'h00FF);

    w0(4'd0, 16'h0080);
    xfr(1'b0, 8'h03);
    chk("tfr_a_x", x, 16'hFF80);
    w0(4'd3, 16'h1111);
    w0(4'd4, 16'h2222);
    xfr(1'b1, 8'h34);
    chk("exg_x", x, 16'h2222);
    chk("exg_y", y, 16'h1111);

    wr0_en = 1; wr0_sel = 4'd2; wr0_data = 16'hA1B2;
    wr1_en = 1; wr1_sel = 4'd1; wr1_data = 16'h00C3;
    cyc();
    chk("d_vs_b", {8'h00, b}, 16'h00B2);

    w0(4'd9, 16'h5555);
    xfr(1'b1, 8'h93);
    chk("exg_inv", x, 16'h0000);
    xfr(1'b1, 8'h00);
    chk("exg_same", {8'h00, a}, 16'h00A1);

    w0(4'd3, 16'hFFFF);
    ptr(2'd0, 1'b0, 1'b1);
    chk("wrap_inc2", x, 16'h0001);

    // asynchronous reset away from any clock edge
    #3 rst = 1'b1;
    #1;
    m_reset();
    check_all();
    rst = 1'b0;

    ptr(2'd2, 1'b1, 1'b0);
    chk("u_dec", u, 16'hFFFF);
    ptr(2'd2, 1'b0, 1'b0);
    chk("u_inc", u, 16'h0000);
    chk("u_nmi", {15'd0, nmi_arm}, 16'h0000);
    ptr(2'd3, 1'b0, 1'b0);
    chk("s_inc", s, 16'h0001);
    ptr(2'd3, 1'b1, 1'b1);
    chk("s_dec2", s, 16'hFFFF);
    chk("s_nmi", {15'd0, nmi_arm}, 16'h0001);

    cen = 1'b0;
    wr0_en = 1; wr0_sel = 4'd5; wr0_data = 16'h7777;
    cyc();
    chk("cen0_u", u, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      cen      = ($urandom_range(0, 7) != 0);
      rd_sel   = 4'($urandom_range(0, 15));
      wr0_en   = $urandom_range(0, 1) == 1;
      wr0_sel  = 4'($urandom_range(0, 10));
      wr0_data = 16'($urandom);
      wr1_en   = $urandom_range(0, 2) == 0;
      wr1_sel  = 4'($urandom_range(0, 10));
      wr1_data = 16'($urandom);
      cc_we    = $urandom_range(0, 1) == 1;
      cc_alu   = 8'($urandom);
      xfr_en   = $urandom_range(0, 2) == 0;
      xfr_exg  = $urandom_range(0, 1) == 1;
      xfr_pb   = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      // D<->A/B exchanges overlap on a byte; keep those as TFR
      if (xfr_pb == 8'h20 || xfr_pb == 8'h02 ||
          xfr_pb == 8'h21 || xfr_pb == 8'h12)
        xfr_exg = 1'b0;
      ptr_en   = $urandom_range(0, 1) == 1;
      ptr_sel  = 2'($urandom_range(0, 3));
      ptr_dec  = $urandom_range(0, 1) == 1;
      ptr_two  = $urandom_range(0, 1) == 1;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
